// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequential BW-bit ALU that holds one operation in flight between the issue
// stage and the writeback stage. Single-cycle opcodes produce a result one
// cycle after acceptance. MUL runs a signed shift-add multiplier for BW
// cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands/opcode valid
//   in_ready   block can accept an operation this cycle (combinational)
//   in_a/in_b  BW-bit two's complement operands
//   opcode     4-bit operation select (0..8 legal, 9..15 illegal)
//   out_valid  out/flags hold a completed result
//   out_ready  consumer accepts the result
//   out        BW-bit result
//   flags      {overflow, negative, zero}, registered together with out
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int BW = 16,
    parameter int SW = $clog2(BW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_a,
    input  logic [BW-1:0] in_b,
    input  logic [3:0]    opcode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out,
    output logic [2:0]    flags
);

    localparam int PW = 2 * BW;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_INC = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_ASR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    // Iteration index of the final (sign-bit) partial product.
    localparam logic [SW-1:0] CNT_LAST = SW'(BW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // {overflow, negative, zero} for a given result.
    function automatic logic [2:0] make_flags(input logic ovf, input logic [BW-1:0] r);
        return {ovf, r[BW-1], (r == {BW{1'b0}})};
    endfunction

    // The signed product fits in BW bits only if its top BW+1 bits are
    // all copies of the sign bit.
    function automatic logic mul_overflow(input logic [PW-1:0] p);
        logic [BW:0] top;
        top = p[PW-1:BW-1];
        return !((&top) || !(|top));
    endfunction

    state_t        state_q, state_d;
    logic [BW-1:0] out_q, out_d;
    logic [2:0]    flags_q, flags_d;
    logic [PW-1:0] mcand_q, mcand_d;
    logic [BW-1:0] mplier_q, mplier_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [SW-1:0] cnt_q, cnt_d;

    logic          in_ready_s;
    logic          accept_s;
    logic [SW-1:0] shamt_s;
    logic [BW-1:0] alu_res_s;
    logic          alu_ovf_s;
    logic [PW-1:0] acc_step_s;

    assign in_ready_s = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign in_ready   = in_ready_s;
    assign out_valid  = (state_q == S_DONE);
    assign out        = out_q;
    assign flags      = flags_q;

    // Single-cycle ALU result and overflow, straight from the input operands.
    always_comb begin
        shamt_s   = in_b[SW-1:0];
        alu_res_s = {BW{1'b0}};
        alu_ovf_s = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res_s = in_a + in_b;
                alu_ovf_s = (in_a[BW-1] == in_b[BW-1]) && (alu_res_s[BW-1] != in_a[BW-1]);
            end
            OP_SUB: begin
                alu_res_s = in_a - in_b;
                alu_ovf_s = (in_a[BW-1] != in_b[BW-1]) && (alu_res_s[BW-1] != in_a[BW-1]);
            end
            OP_AND: alu_res_s = in_a & in_b;
            OP_OR:  alu_res_s = in_a | in_b;
            OP_XOR: alu_res_s = in_a ^ in_b;
            OP_INC: begin
                alu_res_s = in_a + {{(BW-1){1'b0}}, 1'b1};
                // +1 is positive, so only a positive a can overflow.
                alu_ovf_s = !in_a[BW-1] && alu_res_s[BW-1];
            end
            OP_SHL: alu_res_s = in_a << shamt_s;
            OP_ASR: alu_res_s = $unsigned($signed(in_a) >>> shamt_s);
            default: begin
                // MUL is produced by the iterative path; illegal opcodes yield 0.
                alu_res_s = {BW{1'b0}};
                alu_ovf_s = 1'b0;
            end
        endcase
    end

    // One shift-add step. The multiplier's sign bit carries weight
    // -2^(BW-1), so the last partial product is subtracted instead of added.
    always_comb begin
        if (mplier_q[0]) begin
            if (cnt_q == CNT_LAST) begin
                acc_step_s = acc_q - mcand_q;
            end else begin
                acc_step_s = acc_q + mcand_q;
            end
        end else begin
            acc_step_s = acc_q;
        end
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        flags_d  = flags_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    if (opcode == OP_MUL) begin
                        state_d  = S_BUSY;
                        mcand_d  = {{BW{in_a[BW-1]}}, in_a};
                        mplier_d = in_b;
                        acc_d    = {PW{1'b0}};
                        cnt_d    = {SW{1'b0}};
                    end else begin
                        state_d = S_DONE;
                        out_d   = alu_res_s;
                        flags_d = make_flags(alu_ovf_s, alu_res_s);
                    end
                end else if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            S_BUSY: begin
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    out_d   = acc_step_s[BW-1:0];
                    flags_d = make_flags(mul_overflow(acc_step_s), acc_step_s[BW-1:0]);
                    cnt_d   = {SW{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(SW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            out_q    <= {BW{1'b0}};
            flags_q  <= 3'b000;
            mcand_q  <= {PW{1'b0}};
            mplier_q <= {BW{1'b0}};
            acc_q    <= {PW{1'b0}};
            cnt_q    <= {SW{1'b0}};
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            flags_q  <= flags_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
